// File: rtl/mem_arbiter_if.sv
// Core-side ports (instruction and load/store) and memory-side port of the shared memory arbiter.
// The arbiter uses the slave view. The core/memory environment uses the master view.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req_i;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic                  i_gnt_o;
  logic                  i_rvalid_o;
  logic [DATA_WIDTH-1:0] i_rdata_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [3:0]            d_be_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output i_req_i, i_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency single-port memory between the
// instruction-fetch and load/store ports. It allows one outstanding transaction at a time.
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus
);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner_d;
  logic          we_q;
  logic          last_d;

  logic resp, open, gnt_i, gnt_d, acc;

  // The grant window reopens in the response cycle, so back-to-back transactions lose no cycle.
  always_comb begin
    resp  = rst_n && (state == S_WAIT) && (cnt == CW'(1));
    open  = rst_n && ((state == S_IDLE) || resp);
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (open) begin
      if (bus.i_req_i && bus.d_req_i) begin
        gnt_i = last_d;
        gnt_d = !last_d;
      end else begin
        gnt_i = bus.i_req_i;
        gnt_d = bus.d_req_i;
      end
    end
    acc = gnt_i | gnt_d;
  end

  assign bus.i_gnt_o     = gnt_i;
  assign bus.d_gnt_o     = gnt_d;
  assign bus.mem_req_o   = acc;
  assign bus.mem_we_o    = gnt_d & bus.d_we_i;
  assign bus.mem_be_o    = gnt_i ? 4'hF : (gnt_d ? bus.d_be_i : 4'h0);
  assign bus.mem_addr_o  = gnt_i ? bus.i_addr_i : (gnt_d ? bus.d_addr_i : '0);
  assign bus.mem_wdata_o = gnt_d ? bus.d_wdata_i : '0;

  assign bus.i_rvalid_o = resp & !owner_d;
  assign bus.d_rvalid_o = resp & owner_d;
  assign bus.i_rdata_o  = (resp && !owner_d) ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o  = (resp && owner_d && !we_q) ? bus.mem_rdata_i : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      owner_d <= 1'b0;
      we_q    <= 1'b0;
      last_d  <= 1'b1;
    end else if (acc) begin
      state   <= S_WAIT;
      cnt     <= CW'(MEM_LATENCY);
      owner_d <= gnt_d;
      we_q    <= gnt_d & bus.d_we_i;
      last_d  <= gnt_d;
    end else if (resp) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (state == S_WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. A behavioural memory answers L cycles after each strobe.
// Expected responses are queued per port at accept time and popped when rvalid pulses.
module tb_mem_arbiter;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t i_q[$];
  exp_t d_q[$];

  logic [31:0] mem_m [logic [31:0]];
  logic [L-1:0] pv = '0;
  logic [31:0]  pa [L];
  logic         cap_v;
  logic [31:0]  cap_a;

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(L)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : (a ^ 32'hC0DE_0000);
  endfunction

  // The memory latches the strobe at mid-cycle. It presents read data L cycles after the accept and random data otherwise.
  initial begin
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      cap_v = bus.mem_req_o && !bus.mem_we_o;
      cap_a = bus.mem_addr_o;
      if (bus.mem_req_o && bus.mem_we_o) begin
        logic [31:0] w;
        w = rd(bus.mem_addr_o);
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) w[8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
        mem_m[bus.mem_addr_o] = w;
      end
      @(posedge clk); #1;
      for (int k = L-1; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
      pv[0] = cap_v;
      pa[0] = cap_a;
      bus.mem_rdata_i = pv[L-1] ? rd(pa[L-1]) : $urandom;
    end
  end

  // The monitor checks grant exclusivity, idle memory-bus outputs and the response scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_t e;
        chk("one_gnt", 72'(bus.i_gnt_o & bus.d_gnt_o), 72'(0));
        if (!bus.mem_req_o)
          chk("mem_idle_zero", 72'(|{bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}), 72'(0));
        if (bus.i_rvalid_o) begin
          chk("i_rvalid_expected", 72'(i_q.size() != 0), 72'(1));
          if (i_q.size() != 0) begin
            e = i_q.pop_front();
            chk("i_rdata", 72'(bus.i_rdata_o), 72'(e.data));
            chk("i_latency", 72'(cyc), 72'(e.due));
          end
        end else chk("i_rdata_idle", 72'(bus.i_rdata_o), 72'(0));
        if (bus.d_rvalid_o) begin
          chk("d_rvalid_expected", 72'(d_q.size() != 0), 72'(1));
          if (d_q.size() != 0) begin
            e = d_q.pop_front();
            chk("d_rdata", 72'(bus.d_rdata_o), 72'(e.data));
            chk("d_latency", 72'(cyc), 72'(e.due));
          end
        end else chk("d_rdata_idle", 72'(bus.d_rdata_o), 72'(0));
      end
    end
  end

  task automatic i_issue(input logic [31:0] a, output int t);
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = a;
    t = -1;
    for (int k = 0; k < 50 && t < 0; k++) begin
      @(negedge clk);
      if (bus.i_gnt_o) begin
        t = cyc;
        chk("i_mem_drive", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o},
            {1'b1, 1'b0, 4'hF, a, 32'h0});
        i_q.push_back('{rd(a), cyc + L});
      end
      @(posedge clk); #1;
    end
    chk("i_gnt_seen", 72'(t >= 0), 72'(1));
    bus.i_req_i  = 1'b0;
    bus.i_addr_i = '0;
  endtask

  task automatic d_issue(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, output int t);
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = we;
    bus.d_be_i    = be;
    bus.d_addr_i  = a;
    bus.d_wdata_i = wd;
    t = -1;
    for (int k = 0; k < 50 && t < 0; k++) begin
      @(negedge clk);
      if (bus.d_gnt_o) begin
        t = cyc;
        chk("d_mem_drive", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o},
            {1'b1, we, be, a, wd});
        d_q.push_back('{we ? 32'h0 : rd(a), cyc + L});
      end
      @(posedge clk); #1;
    end
    chk("d_gnt_seen", 72'(t >= 0), 72'(1));
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_be_i    = '0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int t0, t1, t, ti[3], td[2];

  initial begin
    mem_m[32'h100] = 32'hDEADBEEF;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h40;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'hF;
    bus.d_addr_i = 32'h80; bus.d_wdata_i = 32'h55;

    // Reset is held with both requests high. Every output must stay 0.
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs_zero", 72'(|{bus.i_gnt_o, bus.i_rvalid_o, bus.i_rdata_o, bus.d_gnt_o, bus.d_rvalid_o,
          bus.d_rdata_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}), 72'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.d_we_i = 1'b0;

    // Both ports request continuously. The first collision goes to I, then the grants alternate.
    t0 = cyc;
    fork
      begin for (int k = 0; k < 3; k++) i_issue(32'h1000 + 32'(k*4), ti[k]); end
      begin for (int k = 0; k < 2; k++) d_issue(1'b0, 4'hF, 32'h2000 + 32'(k*4), 32'h0, td[k]); end
    join
    chk("rr_i0", 72'(ti[0]), 72'(t0));
    chk("rr_d0", 72'(td[0]), 72'(t0 + L));
    chk("rr_i1", 72'(ti[1]), 72'(t0 + 2*L));
    chk("rr_d1", 72'(td[1]), 72'(t0 + 3*L));
    chk("rr_i2", 72'(ti[2]), 72'(t0 + 4*L));
    repeat (L + 2) @(posedge clk); #1;

    // A single instruction read from idle is granted at once and returns DEADBEEF.
    t0 = cyc;
    i_issue(32'h100, t);
    chk("ifetch_gnt", 72'(t), 72'(t0));
    repeat (L + 2) @(posedge clk); #1;

    // A partial write completes with rdata 0. A read-back then returns the merged word.
    d_issue(1'b1, 4'b0011, 32'h2004, 32'h1234, t);
    repeat (L + 1) @(posedge clk); #1;
    d_issue(1'b0, 4'hF, 32'h2004, 32'h0, t);
    repeat (L + 2) @(posedge clk); #1;

    // A D request raised behind an in-flight I transaction waits for the response cycle.
    t0 = cyc;
    fork
      i_issue(32'h400, t1);
      begin @(posedge clk); #1; d_issue(1'b0, 4'hF, 32'h500, 32'h0, t); end
    join
    chk("late_d_i_gnt", 72'(t1), 72'(t0));
    chk("late_d_gnt", 72'(t), 72'(t0 + L));
    repeat (L + 2) @(posedge clk); #1;

    // Reset during a transaction abandons it. A new request is granted in the first cycle after reset.
    i_issue(32'h600, t);
    rst_n = 1'b0;
    i_q.delete();
    d_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    t1 = cyc;
    i_issue(32'h700, t);
    chk("post_rst_gnt", 72'(t), 72'(t1));
    repeat (L + 3) @(posedge clk); #1;

    chk("i_q_drained", 72'(i_q.size()), 72'(0));
    chk("d_q_drained", 72'(d_q.size()), 72'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
